cache_line_mover: RTL and testbench



---
 rtl/cache_line_mover.sv | 149 ++++++++++++++
 tb/tb_cache_line_mover.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_line_mover.sv
// Line transfer engine: writes back a dirty 128-bit victim line, then refills a line as four 32-bit bus reads.
// Optional macro CACHE_WRITEBACK_EN compiles in the dirty-victim write-back path (WB state, req_modify).
module cache_line_mover (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_modify,
    input  logic [27:0]  req_wb_addr,
    input  logic [27:0]  req_fill_addr,
    input  logic [127:0] req_wb_data,
    output logic [31:0]  mem_addr,
    output logic         mem_read,
    output logic         mem_write,
    output logic [31:0]  mem_writedata,
    input  logic         mem_waitrequest,
    input  logic [31:0]  mem_readdata,
    input  logic         mem_readdatavalid,
    output logic [127:0] fill_data,
    output logic [3:0]   fill_word_en,
    output logic         fill_write,
    output logic         fill_read_miss,
    output logic         done
);
    typedef enum logic [2:0] {IDLE, WB, RD, RD_WAIT, FILL} state_t;

    state_t       state;
    logic [1:0]   beat;
    logic [1:0]   beat_nxt;
    logic [27:0]  fill_addr;
    logic [127:0] fill_buf;

    assign beat_nxt  = beat + 2'd1;
    assign req_ready = (state == IDLE) && !rst;
    assign fill_data = fill_buf;

`ifdef CACHE_WRITEBACK_EN
    logic [27:0]  wb_addr;
    logic [127:0] wb_line;
`else
    // Write-through builds never see a dirty victim, so the write-back inputs are dropped.
    logic unused_wb_inputs;
    assign unused_wb_inputs = ^{req_modify, req_wb_addr, req_wb_data};
    assign mem_write        = 1'b0;
    assign mem_writedata    = 32'h0;
`endif

    // Command outputs are registered and loaded with the values of the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            beat           <= 2'd0;
            fill_addr      <= 28'h0;
            fill_buf       <= 128'h0;
            mem_addr       <= 32'h0;
            mem_read       <= 1'b0;
            fill_word_en   <= 4'h0;
            fill_write     <= 1'b0;
            fill_read_miss <= 1'b0;
            done           <= 1'b0;
`ifdef CACHE_WRITEBACK_EN
            wb_addr        <= 28'h0;
            wb_line        <= 128'h0;
            mem_write      <= 1'b0;
            mem_writedata  <= 32'h0;
`endif
        end else begin
            fill_word_en   <= 4'h0;
            fill_write     <= 1'b0;
            fill_read_miss <= 1'b0;
            done           <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        beat      <= 2'd0;
                        fill_addr <= req_fill_addr;
`ifdef CACHE_WRITEBACK_EN
                        wb_addr   <= req_wb_addr;
                        wb_line   <= req_wb_data;
                        if (req_modify) begin
                            state         <= WB;
                            mem_write     <= 1'b1;
                            mem_addr      <= {req_wb_addr, 4'h0};
                            mem_writedata <= req_wb_data[31:0];
                        end else begin
                            state    <= RD;
                            mem_read <= 1'b1;
                            mem_addr <= {req_fill_addr, 4'h0};
                        end
`else
                        state    <= RD;
                        mem_read <= 1'b1;
                        mem_addr <= {req_fill_addr, 4'h0};
`endif
                    end
                end
`ifdef CACHE_WRITEBACK_EN
                WB: begin
                    if (!mem_waitrequest) begin
                        if (beat == 2'd3) begin
                            state         <= RD;
                            beat          <= 2'd0;
                            mem_write     <= 1'b0;
                            mem_writedata <= 32'h0;
                            mem_read      <= 1'b1;
                            mem_addr      <= {fill_addr, 4'h0};
                        end else begin
                            beat          <= beat_nxt;
                            mem_addr      <= {wb_addr, beat_nxt, 2'b00};
                            mem_writedata <= wb_line[{beat_nxt, 5'd0} +: 32];
                        end
                    end
                end
`endif
                RD: begin
                    if (!mem_waitrequest) begin
                        state    <= RD_WAIT;
                        mem_read <= 1'b0;
                        mem_addr <= 32'h0;
                    end
                end
                RD_WAIT: begin
                    if (mem_readdatavalid) begin
                        fill_buf[{beat, 5'd0} +: 32] <= mem_readdata;
                        if (beat == 2'd3) begin
                            state          <= FILL;
                            beat           <= 2'd0;
                            fill_write     <= 1'b1;
                            fill_word_en   <= 4'hf;
                            fill_read_miss <= 1'b1;
                            done           <= 1'b1;
                        end else begin
                            state    <= RD;
                            beat     <= beat_nxt;
                            mem_read <= 1'b1;
                            mem_addr <= {fill_addr, beat_nxt, 2'b00};
                        end
                    end
                end
                FILL: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cache_line_mover.sv
// Directed bench for cache_line_mover: a bus model answers commands, a scoreboard checks bus traffic and fills.
module tb_cache_line_mover;
    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_modify;
    logic [27:0]  req_wb_addr;
    logic [27:0]  req_fill_addr;
    logic [127:0] req_wb_data;
    logic [31:0]  mem_addr;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_writedata;
    logic         mem_waitrequest;
    logic [31:0]  mem_readdata;
    logic         mem_readdatavalid;
    logic [127:0] fill_data;
    logic [3:0]   fill_word_en;
    logic         fill_write;
    logic         fill_read_miss;
    logic         done;

    cache_line_mover dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_modify(req_modify),
        .req_wb_addr(req_wb_addr), .req_fill_addr(req_fill_addr), .req_wb_data(req_wb_data),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_waitrequest(mem_waitrequest),
        .mem_readdata(mem_readdata), .mem_readdatavalid(mem_readdatavalid),
        .fill_data(fill_data), .fill_word_en(fill_word_en), .fill_write(fill_write),
        .fill_read_miss(fill_read_miss), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } cmd_t;

    cmd_t         exp_cmd[$];
    logic [127:0] exp_fill[$];
    int           n_chk  = 0;
    int           n_pass = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    // Presents one request at the current negedge and services the bus until the fill (or an abort).
    task automatic run_txn(input string name, input logic modify, input logic [27:0] wa,
                           input logic [27:0] fa, input logic [127:0] wd, input logic [127:0] rd_line,
                           input int wb_stall_beat, input int rd_stall_beat, input int stall_len,
                           input bit hold_valid, input int abort_rd);
        bit   do_wb;
        bit   rd_pend;
        bit   finished;
        int   t;
        int   exp_t;
        int   w_stall;
        int   r_stall;
        int   n_rd;
        int   n_wr;
        cmd_t e;
`ifdef CACHE_WRITEBACK_EN
        do_wb = modify;
`else
        do_wb = 1'b0;
`endif
        exp_t = 9 + (do_wb ? 4 : 0) + ((do_wb && wb_stall_beat >= 0) ? stall_len : 0)
                + ((rd_stall_beat >= 0) ? stall_len : 0);
        w_stall = stall_len;
        r_stall = stall_len;
        if (do_wb)
            for (int i = 0; i < 4; i++) exp_cmd.push_back('{1'b1, {wa, i[1:0], 2'b00}, wd[32*i +: 32]});
        for (int i = 0; i < 4; i++) exp_cmd.push_back('{1'b0, {fa, i[1:0], 2'b00}, 32'h0});
        exp_fill.push_back(rd_line);

        chk({name, ":ready_at_request"}, req_ready, 1);
        req_valid     = 1'b1;
        req_modify    = modify;
        req_wb_addr   = wa;
        req_fill_addr = fa;
        req_wb_data   = wd;
        t = 0; n_rd = 0; n_wr = 0; rd_pend = 0; finished = 0;
        while (!finished && t < 80) begin
            @(negedge clk);
            t++;
            if (!hold_valid) req_valid = 1'b0;
            if (hold_valid && t == 1) chk({name, ":ready_busy"}, req_ready, 0);
            mem_readdatavalid = 1'b0;
            mem_readdata      = 32'h0;
            mem_waitrequest   = 1'b0;
            if (abort_rd >= 0 && rd_pend && (n_rd - 1) == abort_rd) begin
                rst = 1'b1;
                @(negedge clk);
                chk({name, ":rst_read"}, mem_read, 0);
                chk({name, ":rst_write"}, mem_write, 0);
                chk({name, ":rst_fill_write"}, fill_write, 0);
                chk({name, ":rst_done"}, done, 0);
                chk({name, ":rst_ready"}, req_ready, 0);
                chk({name, ":rst_fill_data"}, fill_data, 0);
                rst = 1'b0;
                @(negedge clk);
                chk({name, ":ready_after_rst"}, req_ready, 1);
                chk({name, ":no_fill_after_rst"}, fill_write, 0);
                exp_cmd.delete();
                exp_fill.delete();
                return;
            end
            if (rd_pend) begin
                mem_readdatavalid = 1'b1;
                mem_readdata      = rd_line[32*(n_rd-1) +: 32];
                rd_pend           = 1'b0;
            end
            if (fill_write) begin
                chk({name, ":fill_time"}, t, exp_t);
                chk({name, ":fill_data"}, fill_data, exp_fill.size() > 0 ? exp_fill.pop_front() : 128'hx);
                chk({name, ":fill_word_en"}, fill_word_en, 4'hf);
                chk({name, ":fill_read_miss"}, fill_read_miss, 1);
                chk({name, ":done"}, done, 1);
                chk({name, ":cmds_left"}, exp_cmd.size(), 0);
                finished = 1'b1;
            end else if (mem_read || mem_write) begin
                if (mem_write && n_wr == wb_stall_beat && w_stall > 0) begin
                    w_stall--;
                    mem_waitrequest = 1'b1;
                    chk({name, ":hold_wr_addr"}, mem_addr, exp_cmd[0].addr);
                    chk({name, ":hold_wr_data"}, mem_writedata, exp_cmd[0].data);
                end else if (mem_read && n_rd == rd_stall_beat && r_stall > 0) begin
                    r_stall--;
                    mem_waitrequest   = 1'b1;
                    mem_readdatavalid = 1'b1;
                    mem_readdata      = 32'hBAD0BAD0;
                    chk({name, ":hold_rd_addr"}, mem_addr, exp_cmd[0].addr);
                end else if (exp_cmd.size() == 0) begin
                    chk({name, ":extra_cmd"}, 1, 0);
                end else begin
                    e = exp_cmd.pop_front();
                    chk({name, ":cmd_exclusive"}, mem_read & mem_write, 0);
                    chk({name, ":cmd_is_write"}, mem_write, e.wr);
                    chk({name, ":cmd_addr"}, mem_addr, e.addr);
                    if (mem_write) begin
                        chk({name, ":cmd_wdata"}, mem_writedata, e.data);
                        n_wr++;
                    end else begin
                        n_rd++;
                        rd_pend = 1'b1;
                    end
                end
            end
        end
        if (!finished) chk({name, ":fill_timeout"}, 0, 1);
        @(negedge clk);
        mem_readdatavalid = 1'b0;
        mem_waitrequest   = 1'b0;
        chk({name, ":ready_after_fill"}, req_ready, 1);
        chk({name, ":single_fill"}, fill_write, 0);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_modify = 1'b0;
        req_wb_addr = 28'h0; req_fill_addr = 28'h0; req_wb_data = 128'h0;
        mem_waitrequest = 1'b0; mem_readdata = 32'h0; mem_readdatavalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset:ready", req_ready, 0);
        chk("reset:read", mem_read, 0);
        chk("reset:write", mem_write, 0);
        chk("reset:addr", mem_addr, 0);
        chk("reset:fill_write", fill_write, 0);
        chk("reset:done", done, 0);
        chk("reset:fill_data", fill_data, 0);
        chk("reset:word_en", fill_word_en, 0);
        rst = 1'b0;
        #1;

        run_txn("clean", 1'b0, 28'h0, 28'h0000123, 128'h0,
                128'h44444444_33333333_22222222_11111111, -1, -1, 0, 1'b0, -1);
        @(negedge clk);
        run_txn("dirty", 1'b1, 28'h00ABCDE, 28'h0000456,
                128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA,
                128'h0F0F0F0F_12345678_CAFEF00D_DEADBEEF, -1, -1, 0, 1'b0, -1);
        @(negedge clk);
        run_txn("stall", 1'b1, 28'h1234567, 28'h7654321,
                128'h01010101_02020202_03030303_04040404,
                128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C, 2, 1, 3, 1'b0, -1);
        run_txn("hold1", 1'b0, 28'h0, 28'h0000ABC, 128'h0,
                128'h00000004_00000003_00000002_00000001, -1, -1, 0, 1'b1, -1);
        run_txn("hold2", 1'b0, 28'h0, 28'h0000DEF, 128'h0,
                128'h80000000_40000000_20000000_10000000, -1, -1, 0, 1'b0, -1);
        @(negedge clk);
        run_txn("abort", 1'b0, 28'h0, 28'h0000321, 128'h0,
                128'h99999999_88888888_77777777_66666666, -1, -1, 0, 1'b0, 2);
        @(negedge clk);
        run_txn("post_rst", 1'b0, 28'h0, 28'h0000654, 128'h0,
                128'hFEDCBA98_76543210_13579BDF_2468ACE0, -1, -1, 0, 1'b0, -1);
        @(negedge clk);
        run_txn("dirty2", 1'b1, 28'hFFFFFFF, 28'h0000000,
                128'hFFFFFFFF_00000000_FFFF0000_0000FFFF,
                128'h11223344_55667788_99AABBCC_DDEEFF00, -1, -1, 0, 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
